// File: rtl/parity_gen.sv
// Parity generator/checker: combinational parity of data_in plus a registered
// capture path (parity, popcount, mismatch flag) and a running XOR accumulator.
module parity_gen #(
    parameter int DATA_W = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              data_in,
    input  logic                           odd_sel,
    input  logic                           in_valid,
    input  logic                           parity_in,
    input  logic                           acc_clr,
    output logic                           parity_out,
    output logic                           parity_q,
    output logic                           out_valid,
    output logic                           check_err,
    output logic                           acc_parity,
    output logic [$clog2(DATA_W+1)-1:0]    ones_cnt
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic             data_xor;
    logic [CNT_W-1:0] ones_next;

    assign data_xor   = ^data_in;
    assign parity_out = data_xor ^ odd_sel;

    always_comb begin
        ones_next = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            ones_next = ones_next + CNT_W'(data_in[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q   <= 1'b0;
            out_valid  <= 1'b0;
            check_err  <= 1'b0;
            acc_parity <= 1'b0;
            ones_cnt   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                parity_q  <= parity_out;
                check_err <= (parity_in != parity_out);
                ones_cnt  <= ones_next;
            end
            // Clear wins over a word accepted on the same edge; odd_sel never enters the accumulator.
            if (acc_clr) begin
                acc_parity <= 1'b0;
            end else if (in_valid) begin
                acc_parity <= acc_parity ^ data_xor;
            end
        end
    end

endmodule

// File: tb/tb_parity_gen.sv
// Scoreboard bench for parity_gen: stimulus pushes per-cycle expectations from a
// popcount-based reference model; a monitor pops and compares after each edge.
module tb_parity_gen;

    localparam int DW = 4;
    localparam int CW = $clog2(DW + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          odd_sel = 1'b0;
    logic          in_valid = 1'b0;
    logic          parity_in = 1'b0;
    logic          acc_clr = 1'b0;
    logic          parity_out, parity_q, out_valid, check_err, acc_parity;
    logic [CW-1:0] ones_cnt;

    parity_gen #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .odd_sel(odd_sel),
        .in_valid(in_valid), .parity_in(parity_in), .acc_clr(acc_clr),
        .parity_out(parity_out), .parity_q(parity_q), .out_valid(out_valid),
        .check_err(check_err), .acc_parity(acc_parity), .ones_cnt(ones_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          pq;
        logic [CW-1:0] cnt;
        logic          err;
        logic          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference state: what the registered outputs should hold after each edge.
    logic          m_pq = 1'b0, m_err = 1'b0, m_acc = 1'b0;
    logic [CW-1:0] m_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic ref_parity(input logic [DW-1:0] d, input logic odd);
        return logic'($countones(d) % 2) ^ odd;
    endfunction

    task automatic drive(input logic r, input logic v, input logic [DW-1:0] d,
                         input logic odd, input logic pin, input logic clr);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = v; data_in = d; odd_sel = odd; parity_in = pin; acc_clr = clr;
        if (r) begin
            m_pq = 1'b0; m_err = 1'b0; m_acc = 1'b0; m_cnt = '0;
            e.v = 1'b0;
        end else begin
            e.v = v;
            if (v) begin
                m_pq  = ref_parity(d, odd);
                m_err = (pin != ref_parity(d, odd));
                m_cnt = CW'($countones(d));
            end
            if (clr) m_acc = 1'b0;
            else if (v) m_acc = m_acc ^ logic'($countones(d) % 2);
        end
        e.pq = m_pq; e.cnt = m_cnt; e.err = m_err; e.acc = m_acc;
        exp_q.push_back(e);
        #1;
        check("parity_out", 64'(parity_out), 64'(ref_parity(d, odd)));
        if (r) begin
            check("rst_now_parity_q", 64'(parity_q), 64'd0);
            check("rst_now_out_valid", 64'(out_valid), 64'd0);
            check("rst_now_check_err", 64'(check_err), 64'd0);
            check("rst_now_acc_parity", 64'(acc_parity), 64'd0);
            check("rst_now_ones_cnt", 64'(ones_cnt), 64'd0);
        end
    endtask

    // Monitor: one expectation per edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid", 64'(out_valid), 64'(e.v));
                check("parity_q", 64'(parity_q), 64'(e.pq));
                check("ones_cnt", 64'(ones_cnt), 64'(e.cnt));
                check("check_err", 64'(check_err), 64'(e.err));
                check("acc_parity", 64'(acc_parity), 64'(e.acc));
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        #1;
        check("reset_parity_q", 64'(parity_q), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_ones_cnt", 64'(ones_cnt), 64'd0);
        check("reset_acc_parity", 64'(acc_parity), 64'd0);
        check("reset_parity_out", 64'(parity_out), 64'd0);

        drive(1'b1, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b0);
        // First word right after reset release
        drive(1'b0, 1'b1, 4'b0101, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Full sweep, even then odd sense, back-to-back
        for (int o = 0; o < 2; o++)
            for (int i = 0; i < 16; i++)
                drive(1'b0, 1'b1, DW'(i), logic'(o), logic'($urandom_range(0, 1)), 1'b0);

        drive(1'b0, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);

        // Accumulator sequence from a cleared state, then clear beats a valid word
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);

        // Hold for three idle cycles after a word with nonzero outputs
        drive(1'b0, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, DW'($urandom), 1'b1, 1'b1, 1'b0);

        // Mid-stream reset while outputs are nonzero
        drive(1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 300; k++) begin
            d = DW'($urandom);
            drive(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 3) != 0), d,
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 9) == 0));
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
